// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised oversampling UART receiver with parity and stop-bit checking
module uart_rx_param #(
    parameter int DIVISOR   = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    output logic                 rcv,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(DIVISOR);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF      = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL      = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_EXP   = (PARITY == 1);

    generate
        if (DIVISOR < 4 || DIVISOR > 65535) begin : g_err_divisor
            $error("uart_rx_param: DIVISOR must be 4..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
            $error("uart_rx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_err_parity
            $error("uart_rx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop_bits
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err_n;
    logic                   r_frm_err_n;
    logic                   r_rcv;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   w_full;
    logic                   w_counting;
    logic                   w_enter;

    always_comb begin
        w_next     = r_state;
        w_full     = (r_cnt == FULL);
        w_counting = 1'b0;
        case (r_state)
            IDLE:  if (!r_rx_s) w_next = START;
            START: begin
                w_counting = 1'b1;
                // mid-start-bit recheck rejects short low glitches
                if (r_cnt == HALF) w_next = r_rx_s ? IDLE : DATA;
            end
            DATA: begin
                w_counting = 1'b1;
                if (w_full && r_bit_cnt == LAST_BIT) w_next = (PARITY != 0) ? PAR : STOP;
            end
            PAR: begin
                w_counting = 1'b1;
                if (w_full) w_next = STOP;
            end
            STOP: begin
                w_counting = 1'b1;
                if (w_full && r_bit_cnt == LAST_STOP) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_enter = (w_next != r_state);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= IDLE;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err_n <= 1'b0;
            r_frm_err_n <= 1'b0;
        end else begin
            if (w_enter || (w_full && w_counting)) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + CW'(1);
            end

            // bit counter doubles as the stop-bit counter
            if (w_enter) begin
                r_bit_cnt <= '0;
            end else if (w_full && (r_state == DATA || r_state == STOP)) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end

            if (r_state == DATA && w_full) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end

            if (r_state == IDLE && w_next == START) begin
                r_par_err_n <= 1'b0;
                r_frm_err_n <= 1'b0;
            end else begin
                if (r_state == PAR && w_full) begin
                    r_par_err_n <= (^r_shift) ^ r_rx_s ^ ODD_EXP;
                end
                if (r_state == STOP && w_full && !r_rx_s) begin
                    r_frm_err_n <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rcv        <= 1'b0;
            r_data       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rcv <= (r_state == DONE);
            if (r_state == DONE) begin
                r_data       <= r_shift;
                r_parity_err <= (PARITY != 0) ? r_par_err_n : 1'b0;
                r_frame_err  <= r_frm_err_n;
            end
        end
    end

    assign rcv        = r_rcv;
    assign data       = r_data;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param across 8N1, even-parity and two-stop configurations
module tb_uart_rx_param;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] rx_v;
    logic [2:0] rcv_w;
    logic [2:0] perr_w;
    logic [2:0] ferr_w;
    logic [2:0] busy_w;
    logic [7:0] data_w [3];

    always #5 clk = ~clk;

    uart_rx_param #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
        .clk(clk), .rstn(rstn), .rx(rx_v[0]), .rcv(rcv_w[0]), .data(data_w[0]),
        .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .busy(busy_w[0]));

    uart_rx_param #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8e1 (
        .clk(clk), .rstn(rstn), .rx(rx_v[1]), .rcv(rcv_w[1]), .data(data_w[1]),
        .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .busy(busy_w[1]));

    uart_rx_param #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_8n2 (
        .clk(clk), .rstn(rstn), .rx(rx_v[2]), .rcv(rcv_w[2]), .data(data_w[2]),
        .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .busy(busy_w[2]));

    typedef struct {
        int         dut;
        logic [15:0] bits;
        int         nbits;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         n_rcv [3] = '{0, 0, 0};
    int         rcv_cyc [3] = '{0, 0, 0};
    logic [7:0] q0 [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rcv_w[i] === 1'b1) begin
                n_rcv[i]   = n_rcv[i] + 1;
                rcv_cyc[i] = cyc;
                if (i == 0) q0.push_back(data_w[0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_v[idx] = bits[i];
            if (i == 0) fall_cyc = cyc;
            tick(DIV);
        end
        rx_v[idx] = 1'b1;
    endtask

    task automatic wait_rcv(input int idx, input int base, input int budget);
        for (int i = 0; i < budget && n_rcv[idx] <= base; i++) tick(1);
    endtask

    vec_t       vecs [7];
    int         base;
    int         lat;
    logic [7:0] exp_last0;
    logic [7:0] d0;
    logic [7:0] d1;

    initial begin
        vecs[0] = '{0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 8'h07, 1'b1, 1'b0};
        vecs[4] = '{2, {5'b0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, 8'h5A, 1'b0, 1'b1};
        vecs[5] = '{2, {5'b0, 2'b11, 8'h81, 1'b0}, 11, 8'h81, 1'b0, 1'b0};
        vecs[6] = '{0, {6'b0, 1'b0, 8'h96, 1'b0}, 10, 8'h96, 1'b0, 1'b1};

        rstn = 1'b0;
        rx_v = 3'b111;
        tick(5);
        chk("rst_rcv",  {31'b0, rcv_w[0]},  32'd0);
        chk("rst_data", {24'b0, data_w[0]}, 32'd0);
        chk("rst_perr", {31'b0, perr_w[1]}, 32'd0);
        chk("rst_ferr", {31'b0, ferr_w[2]}, 32'd0);
        chk("rst_busy", {29'b0, busy_w},    32'd0);
        rstn = 1'b1;
        tick(4);

        for (int v = 0; v < 7; v++) begin
            base = n_rcv[vecs[v].dut];
            send_frame(vecs[v].dut, vecs[v].bits, vecs[v].nbits);
            tick(2 * DIV);
            chk($sformatf("v%0d_rcv_count", v), n_rcv[vecs[v].dut] - base, 1);
            chk($sformatf("v%0d_data", v), {24'b0, data_w[vecs[v].dut]}, {24'b0, vecs[v].exp_data});
            chk($sformatf("v%0d_perr", v), {31'b0, perr_w[vecs[v].dut]}, {31'b0, vecs[v].exp_perr});
            chk($sformatf("v%0d_ferr", v), {31'b0, ferr_w[vecs[v].dut]}, {31'b0, vecs[v].exp_ferr});
            if (v == 0) begin
                // 2 + DIV/2 + 9*DIV + 1 = 155 cycles, +-1
                lat = rcv_cyc[0] - fall_cyc;
                n_chk++;
                if (lat < 154 || lat > 156) $display("FAIL latency: got %0d expected 154..156", lat);
                else n_pass++;
            end
            if (vecs[v].dut == 0) exp_last0 = vecs[v].exp_data;
        end

        base = n_rcv[0];
        rx_v[0] = 1'b0;
        tick(5);
        chk("glitch_busy_high", {31'b0, busy_w[0]}, 32'd1);
        rx_v[0] = 1'b1;
        tick(40);
        chk("glitch_no_rcv", n_rcv[0] - base, 0);
        chk("glitch_busy_low", {31'b0, busy_w[0]}, 32'd0);
        chk("glitch_data_kept", {24'b0, data_w[0]}, {24'b0, exp_last0});

        base = n_rcv[0];
        q0.delete();
        send_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        send_frame(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10);
        tick(2 * DIV);
        d0 = (q0.size() > 0) ? q0[0] : 8'hxx;
        d1 = (q0.size() > 1) ? q0[1] : 8'hxx;
        chk("b2b_count", n_rcv[0] - base, 2);
        chk("b2b_first", {24'b0, d0}, 32'h55);
        chk("b2b_second", {24'b0, d1}, 32'hFF);

        base = n_rcv[0];
        rx_v[0] = 1'b0;
        wait_rcv(0, base, 400);
        chk("brk_rcv_seen", {31'b0, n_rcv[0] > base}, 32'd1);
        chk("brk_data", {24'b0, data_w[0]}, 32'd0);
        chk("brk_ferr", {31'b0, ferr_w[0]}, 32'd1);
        tick(20);
        chk("brk_restart_busy", {31'b0, busy_w[0]}, 32'd1);
        rx_v[0] = 1'b1;
        tick(400);

        base = n_rcv[0];
        rx_v[0] = 1'b0;
        tick(DIV);
        rx_v[0] = 1'b0; tick(DIV);
        rx_v[0] = 1'b1; tick(DIV);
        rx_v[0] = 1'b0; tick(DIV);
        rx_v[0] = 1'b0; tick(DIV / 2);
        rstn = 1'b0;
        #1;
        chk("mid_rst_rcv",  {31'b0, rcv_w[0]},  32'd0);
        chk("mid_rst_data", {24'b0, data_w[0]}, 32'd0);
        chk("mid_rst_perr", {31'b0, perr_w[0]}, 32'd0);
        chk("mid_rst_ferr", {31'b0, ferr_w[0]}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_w[0]}, 32'd0);
        rx_v[0] = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(200);
        chk("mid_rst_no_rcv", n_rcv[0] - base, 0);
        send_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        tick(2 * DIV);
        chk("post_rst_count", n_rcv[0] - base, 1);
        chk("post_rst_data", {24'b0, data_w[0]}, 32'h3C);
        chk("post_rst_perr", {31'b0, perr_w[0]}, 32'd0);
        chk("post_rst_ferr", {31'b0, ferr_w[0]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DIVISOR, default 104: clk cycles per bit period; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx  input  1  asynchronous serial line; idle high; LSB first.
REQ-008 SHALL have port rcv  output  1  one-cycle pulse: frame complete; data and flags valid.
REQ-009 SHALL have port data  output  DATA_BITS  last received word, held until the next rcv.
REQ-010 SHALL have port parity_err  output  1  parity mismatch on the last frame; valid with rcv, held until the next rcv.
REQ-011 SHALL have port frame_err  output  1  a stop bit sampled low on the last frame; valid with rcv, held until the next rcv.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass rx through a two-flop synchroniser (rx_s); all decisions use rx_s only.
REQ-014 SHALL use FSM states IDLE, START, DATA, PAR, STOP, DONE.
REQ-015 SHALL use a baud counter cnt of width ceil(log2(DIVISOR)), cleared on every state entry and incremented every cycle in START, DATA, PAR and STOP.
REQ-016 IDLE: rx_s==0 -> START; otherwise stay in IDLE.
REQ-017 START: at cnt==DIVISOR/2-1 (integer division), sample rx_s; 1 -> IDLE (glitch rejected, no rcv, flags unchanged); 0 -> DATA with cnt and bit counter cleared.
REQ-018 DATA: at cnt==DIVISOR-1, shift rx_s into the shift register MSB (LSB-first reception), increment the bit counter, and clear cnt; after the DATA_BITS-th sample -> PAR if PARITY!=0, else STOP.
REQ-019 PAR: at cnt==DIVISOR-1, capture the parity bit; parity_err_next = (XOR of data bits ^ parity bit) != (PARITY==1 ? 1 : 0); then -> STOP.
REQ-020 STOP: at each cnt==DIVISOR-1, sample a stop bit; any sample equal to 0 sets frame_err_next; after STOP_BITS samples -> DONE. No further wait follows the last stop-bit sample.
REQ-021 DONE: lasts one cycle; data <= shift register, parity_err <= parity_err_next (0 when PARITY==0), frame_err <= frame_err_next, rcv=1; then -> IDLE.
REQ-022 All samples SHALL therefore fall at mid-bit ±1 cycle.
REQ-023 Latency: rcv SHALL assert 2 + DIVISOR/2 + (DATA_BITS + P + STOP_BITS)*DIVISOR + 1 cycles after the rx falling edge (±1), where P = (PARITY!=0).
REQ-024 rx activity in any state other than IDLE or START SHALL NOT alter the state sequence; only the sample points matter.
REQ-025 After DONE, a start bit already low SHALL be accepted on the first IDLE cycle, giving back-to-back frames with no lost character.
REQ-026 A frame error SHALL still deliver data and rcv.
REQ-027 Line held low (break) SHALL yield a frame with data=0 and frame_err=1, then restart reception while the line stays low.
REQ-028 rcv, parity_err, frame_err and data SHALL be registered outputs.
REQ-029 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-030 rstn=0 SHALL immediately force state=IDLE, rcv=0, data=0, parity_err=0, frame_err=0, busy=0, with cnt, bit counter and shift register cleared, and synchroniser flops set to 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no rcv; after release, reception resumes at the next falling edge of rx_s.
REQ-032 Reset release SHALL be taken synchronously to clk (deassertion only).

Verification
REQ-033 DIVISOR=16, 8N1, send 0xA5 -> exactly one rcv pulse, data=0xA5, parity_err=0, frame_err=0, rcv within ±1 cycle of REQ-023.
REQ-034 PARITY=2, send 0x07 with parity bit 1 -> data=0x07, parity_err=0; same byte with parity bit 0 -> parity_err=1.
REQ-035 Low glitch of 5 cycles at DIVISOR=16 -> no rcv, busy returns low, outputs unchanged.
REQ-036 STOP_BITS=2, second stop bit driven 0 -> frame_err=1, data correct.
REQ-037 Two back-to-back 8N1 frames 0x55, 0xFF with no idle gap -> two rcv pulses, data 0x55 then 0xFF.
REQ-038 rstn pulsed low at bit 4 of a frame -> no rcv, all outputs 0; the following frame 0x3C is received correctly.
